// File: rtl/bcd_8bit_counter.sv
// bcd_8bit_counter: two-digit BCD up-counter 00..99; clk, clr (sync active-high clear to 00), q0 units digit, q1 tens digit
module bcd_8bit_counter (
  input  logic       clk,
  input  logic       clr,
  output logic [3:0] q0,
  output logic [3:0] q1
);
  logic c0;
  assign c0 = q0 >= 4'd9;
  always_ff @(posedge clk)
    if (clr) begin
      q0 <= 4'd0;
      q1 <= 4'd0;
    end else begin
      q0 <= c0 ? 4'd0 : q0 + 4'd1;
      if (c0) q1 <= (q1 >= 4'd9) ? 4'd0 : q1 + 4'd1;
    end
endmodule

// File: tb/tb_bcd_8bit_counter.sv
// tb_bcd_8bit_counter: directed bench for the two-digit BCD counter
module tb_bcd_8bit_counter;
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic [3:0] q0, q1;
  int vectors = 0;
  int miscompares = 0;
  int cnt = 0;
  logic [7:0] prev;

  bcd_8bit_counter dut (.clk(clk), .clr(clr), .q0(q0), .q1(q1));

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    logic c;
    c = clr;
    prev = {q1, q0};
    @(posedge clk);
    #1;
    cnt = c ? 0 : (cnt + 1) % 100;
    check("count", {q1, q0}, bcd(cnt));
    check("legal", {7'd0, q0 <= 4'd9 && q1 <= 4'd9}, 8'd1);
    if (!c) check("step", {q1, q0}, (prev == 8'h99) ? 8'h00 : bcd((prev[7:4] * 10 + prev[3:0] + 1) % 100));
  endtask

  initial begin
    tick();
    tick();
    check("reset", {q1, q0}, 8'h00);
    #4;
    clr = 1'b0;
    for (int i = 1; i <= 48; i++) begin
      tick();
      if (i == 1) check("t25", {q1, q0}, 8'h01);
      if (i == 9) check("t105", {q1, q0}, 8'h09);
      if (i == 10) check("t115_carry", {q1, q0}, 8'h10);
    end
    check("t495", {q1, q0}, 8'h48);
    repeat (51) tick();
    check("full", {q1, q0}, 8'h99);
    tick();
    check("wrap", {q1, q0}, 8'h00);
    repeat (57) tick();
    check("pre_clr", {q1, q0}, 8'h57);
    clr = 1'b1;
    tick();
    check("clr_mid", {q1, q0}, 8'h00);
    clr = 1'b0;
    tick();
    check("after_clr", {q1, q0}, 8'h01);
    repeat (98) tick();
    check("at99", {q1, q0}, 8'h99);
    clr = 1'b1;
    tick();
    check("clr_at99", {q1, q0}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("clr_hold", {q1, q0}, 8'h00);
    end
    clr = 1'b0;
    tick();
    check("resume", {q1, q0}, 8'h01);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
